// File: rtl/strontium_mem_pkg.sv
// Shared types for the data-memory write path: buffer depth default and entry layout.
// Entries hold word addresses only; byte offsets are never stored.
package strontium_mem_pkg;

    localparam int WB_DEPTH = 4;
    localparam int WB_AW    = 32;
    localparam int WB_DW    = 32;
    localparam int WB_WAW   = WB_AW - 2;

    typedef struct packed {
        logic [WB_WAW-1:0] addr;
        logic [WB_DW-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wbuf_fwd_match.sv
// Combinational youngest-hit select over the write-buffer entries.
// Latency 0; no flow control, pure lookup.
module wbuf_fwd_match
    import strontium_mem_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  wb_entry_t         entries_i [DEPTH],
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [PW-1:0]     wr_ptr_i,
    input  logic [WB_WAW-1:0] qaddr_i,
    output logic              hit_o,
    output logic [WB_DW-1:0]  data_o
);

    logic [PW-1:0] idx;

    // Walk backwards from the slot just behind wr_ptr so the first hit is the youngest store.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            idx = wr_ptr_i - PW'(k);
            if (!hit_o && valid_i[idx] && (entries_i[idx].addr == qaddr_i)) begin
                hit_o  = 1'b1;
                data_o = entries_i[idx].data;
            end
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-write FIFO between Core stores and the memory write channel, with load forwarding.
// Store visible on bus 1 cycle after issue; pause only when a store meets a full buffer.
module dmem_write_buffer
    import strontium_mem_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    input  logic [AW-1:0] core_fetch_addr,
    output logic [DW-1:0] core_rdata,
    output logic          pause,
    output logic [AW-1:0] mem_raddr,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_wvalid,
    output logic [AW-1:0] mem_waddr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_wready,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_entry_t        entry_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             enq;
    logic             deq;
    logic [DEPTH-1:0] valid_mask;
    logic             fwd_hit;
    logic [DW-1:0]    fwd_data;
    logic             addr_lo_unused;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign enq   = core_we & ~full;
    assign deq   = ~empty & mem_wready;
    assign pause = core_we & full;

    // Low address bits select bytes within a word and play no part in matching.
    assign addr_lo_unused = ^core_addr[1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry payloads need no reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_q[wr_ptr_q] <= '{addr: core_addr[AW-1:2], data: core_wdata};
        end
    end

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        valid_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_mask[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
        end
    end

    wbuf_fwd_match #(
        .DEPTH (DEPTH)
    ) u_fwd_match (
        .entries_i (entry_q),
        .valid_i   (valid_mask),
        .wr_ptr_i  (wr_ptr_q),
        .qaddr_i   (core_fetch_addr[AW-1:2]),
        .hit_o     (fwd_hit),
        .data_o    (fwd_data)
    );

    assign core_rdata = fwd_hit ? fwd_data : mem_rdata;
    assign mem_raddr  = core_fetch_addr;

    // Drain outputs come straight from registered state, so mem_wready never reaches them.
    assign mem_wvalid = ~empty;
    assign mem_waddr  = {entry_q[rd_ptr_q].addr, 2'b00};
    assign mem_wdata  = entry_q[rd_ptr_q].data;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer: stores, forwarding, stall, wrap and reset.
module tb_dmem_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_fetch_addr;
    logic [31:0] core_rdata;
    logic        pause;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_wvalid;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_wready;
    logic        empty;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dmem_write_buffer dut (
        .clk             (clk),
        .reset           (reset),
        .core_we         (core_we),
        .core_addr       (core_addr),
        .core_wdata      (core_wdata),
        .core_fetch_addr (core_fetch_addr),
        .core_rdata      (core_rdata),
        .pause           (pause),
        .mem_raddr       (mem_raddr),
        .mem_rdata       (mem_rdata),
        .mem_wvalid      (mem_wvalid),
        .mem_waddr       (mem_waddr),
        .mem_wdata       (mem_wdata),
        .mem_wready      (mem_wready),
        .empty           (empty)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        core_fetch_addr = '0; mem_rdata = '0; mem_wready = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (mem_wvalid !== 1'b0) begin failures++; $display("FAIL reset_wvalid got %b exp 0", mem_wvalid); end
        checks++; if (pause !== 1'b0) begin failures++; $display("FAIL reset_pause got %b exp 0", pause); end
        core_we = 1'b1; core_fetch_addr = 32'h0000_0abc; mem_rdata = 32'h1234_5678;
        #1;
        checks++; if (pause !== 1'b0) begin failures++; $display("FAIL reset_pause_we got %b exp 0", pause); end
        checks++; if (mem_raddr !== 32'h0000_0abc) begin failures++; $display("FAIL raddr_pass got %h exp 00000abc", mem_raddr); end
        checks++; if (core_rdata !== 32'h1234_5678) begin failures++; $display("FAIL rdata_miss got %h exp 12345678", core_rdata); end
        core_we = 1'b0;
    endtask

    task automatic test_single_store();
        do_reset();
        core_we = 1'b1; core_addr = 32'h100; core_wdata = 32'hDEADBEEF; mem_wready = 1'b1;
        step();
        core_we = 1'b0;
        #1;
        checks++; if (mem_wvalid !== 1'b1) begin failures++; $display("FAIL single_wvalid got %b exp 1", mem_wvalid); end
        checks++; if (mem_waddr !== 32'h100) begin failures++; $display("FAIL single_waddr got %h exp 00000100", mem_waddr); end
        checks++; if (mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_wdata got %h exp deadbeef", mem_wdata); end
        step();
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_empty got %b exp 1", empty); end
        checks++; if (mem_wvalid !== 1'b0) begin failures++; $display("FAIL single_wvalid_after got %b exp 0", mem_wvalid); end
    endtask

    task automatic test_forward_youngest();
        do_reset();
        mem_rdata = 32'h99;
        core_we = 1'b1; core_addr = 32'h200; core_wdata = 32'h11;
        step();
        core_addr = 32'h200; core_wdata = 32'h22; core_fetch_addr = 32'h200;
        #1;
        // Second store is in flight this cycle and must not be seen yet.
        checks++; if (core_rdata !== 32'h11) begin failures++; $display("FAIL fwd_no_same_cycle got %h exp 00000011", core_rdata); end
        step();
        core_we = 1'b0; core_fetch_addr = 32'h202;
        #1;
        checks++; if (core_rdata !== 32'h22) begin failures++; $display("FAIL fwd_youngest got %h exp 00000022", core_rdata); end
        core_fetch_addr = 32'h204;
        #1;
        checks++; if (core_rdata !== 32'h99) begin failures++; $display("FAIL fwd_miss got %h exp 00000099", core_rdata); end
        mem_wready = 1'b1; core_fetch_addr = 32'h200;
        #1;
        checks++; if (core_rdata !== 32'h22) begin failures++; $display("FAIL fwd_during_deq got %h exp 00000022", core_rdata); end
        step();
        #1;
        checks++; if (core_rdata !== 32'h22) begin failures++; $display("FAIL fwd_one_left got %h exp 00000022", core_rdata); end
        step();
        #1;
        checks++; if (core_rdata !== 32'h99) begin failures++; $display("FAIL fwd_drained got %h exp 00000099", core_rdata); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL fwd_empty got %b exp 1", empty); end
    endtask

    task automatic test_full_stall();
        logic [31:0] exp_order [4];
        exp_order[0] = 32'h4; exp_order[1] = 32'h8; exp_order[2] = 32'hC; exp_order[3] = 32'h10;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            core_we = 1'b1; core_addr = 32'(i * 4); core_wdata = 32'(32'h40 + i);
            step();
        end
        core_addr = 32'h10; core_wdata = 32'h50;
        #1;
        checks++; if (pause !== 1'b1) begin failures++; $display("FAIL stall_pause got %b exp 1", pause); end
        step();
        #1;
        checks++; if (pause !== 1'b1) begin failures++; $display("FAIL stall_pause_held got %b exp 1", pause); end
        mem_wready = 1'b1;
        #1;
        checks++; if (pause !== 1'b1) begin failures++; $display("FAIL stall_pause_deq_cycle got %b exp 1", pause); end
        checks++; if (mem_waddr !== 32'h0) begin failures++; $display("FAIL stall_first_addr got %h exp 00000000", mem_waddr); end
        step();
        mem_wready = 1'b0;
        #1;
        checks++; if (pause !== 1'b0) begin failures++; $display("FAIL stall_release got %b exp 0", pause); end
        step();
        core_we = 1'b0;
        #1;
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL stall_refill_empty got %b exp 0", empty); end
        mem_wready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (mem_wvalid !== 1'b1 || mem_waddr !== exp_order[i])
                begin failures++; $display("FAIL stall_drain_%0d got v=%b a=%h exp v=1 a=%h", i, mem_wvalid, mem_waddr, exp_order[i]); end
            step();
        end
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL stall_drain_empty got %b exp 1", empty); end
    endtask

    task automatic test_wrap_simultaneous();
        logic [31:0] q_addr [$];
        logic [31:0] q_data [$];
        int issued = 0;
        int drained = 0;
        bit done = 0;
        bit do_deq;
        bit do_enq;
        do_reset();
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            mem_wready = cyc[0];
            core_we    = (issued < 12);
            core_addr  = 32'h400 + 32'(issued * 4);
            core_wdata = 32'hA0 + 32'(issued);
            #1;
            checks++; if (pause !== (core_we && q_addr.size() == 4))
                begin failures++; $display("FAIL wrap_pause cyc %0d got %b exp %b", cyc, pause, core_we && q_addr.size() == 4); end
            checks++; if (mem_wvalid !== (q_addr.size() != 0))
                begin failures++; $display("FAIL wrap_wvalid cyc %0d got %b exp %b", cyc, mem_wvalid, q_addr.size() != 0); end
            if (q_addr.size() != 0) begin
                checks++; if (mem_waddr !== q_addr[0] || mem_wdata !== q_data[0])
                    begin failures++; $display("FAIL wrap_head cyc %0d got %h/%h exp %h/%h", cyc, mem_waddr, mem_wdata, q_addr[0], q_data[0]); end
            end
            do_deq = (q_addr.size() != 0) && mem_wready;
            do_enq = core_we && (q_addr.size() != 4);
            if (do_deq) begin
                void'(q_addr.pop_front()); void'(q_data.pop_front()); drained++;
            end
            if (do_enq) begin
                q_addr.push_back(core_addr); q_data.push_back(core_wdata); issued++;
            end
            step();
            done = (drained == 12);
        end
        core_we = 1'b0; mem_wready = 1'b0;
        checks++; if (!done) begin failures++; $display("FAIL wrap_timeout drained %0d exp 12", drained); end
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got %b exp 1", empty); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            core_we = 1'b1; core_addr = 32'h300 + 32'(i * 4); core_wdata = 32'hC0 + 32'(i);
            step();
        end
        core_we = 1'b0; core_fetch_addr = 32'h304; mem_rdata = 32'h77;
        #1;
        checks++; if (core_rdata !== 32'hC1) begin failures++; $display("FAIL rst_pre_fwd got %h exp 000000c1", core_rdata); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rst_mid_empty got %b exp 1", empty); end
        checks++; if (mem_wvalid !== 1'b0) begin failures++; $display("FAIL rst_mid_wvalid got %b exp 0", mem_wvalid); end
        checks++; if (pause !== 1'b0) begin failures++; $display("FAIL rst_mid_pause got %b exp 0", pause); end
        checks++; if (core_rdata !== 32'h77) begin failures++; $display("FAIL rst_mid_rdata got %h exp 00000077", core_rdata); end
    endtask

    initial begin
        test_reset();
        test_single_store();
        test_forward_youngest();
        test_full_stall();
        test_wrap_simultaneous();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_write_buffer.md
# dmem_write_buffer

- Posted-write buffer between the Core's data-memory port and the shared data-memory bus.
- Accepts Core stores in the cycle they are issued and holds them in a small FIFO. Drains them to memory over a valid/ready write channel.
- Forwards buffered data to Core loads so reads always see program-order memory state.
- Raises the Core's `pause` input only when a store arrives while the buffer is full.

## Interface
Parameters:
- `DEPTH`, 4: buffer entries; power of two, ≥2.
- `AW`, 32: address width.
- `DW`, 32: data width (full-word stores only).

Ports (one clock; `reset` is synchronous and active-high):
- `clk`  in  1  system clock
- `reset`  in  1  synchronous active-high reset
- `core_we`  in  1  store request (Core `DMEM_we`)
- `core_addr`  in  AW  store address (Core `DMEM_addr`)
- `core_wdata`  in  DW  store data (Core `DMEM_wdata`)
- `core_fetch_addr`  in  AW  load address (Core `fetch_DMEM_addr`)
- `core_rdata`  out  DW  load data to Core (`DMEM_rdata`), combinational
- `pause`  out  1  stall to Core, combinational
- `mem_raddr`  out  AW  async read address to memory, equal to `core_fetch_addr`
- `mem_rdata`  in  DW  async read data from memory
- `mem_wvalid`  out  1  head entry presented
- `mem_waddr`  out  AW  head entry address
- `mem_wdata`  out  DW  head entry data
- `mem_wready`  in  1  memory accepts head entry
- `empty`  out  1  no buffered stores (for fences/drain checks)

## Operation
- Storage: `DEPTH` entries of {word address `addr[AW-1:2]`, data}. State also holds `wr_ptr`, `rd_ptr`, and `count` (log2(DEPTH)+1 bits).
- `full` = (`count` == `DEPTH`). `empty` = (`count` == 0).
- **Enqueue:** at the edge when `core_we & ~full`. Write entry[`wr_ptr`] and increment `wr_ptr` (wraps mod `DEPTH`).
- **Dequeue:** at the edge when `mem_wvalid & mem_wready`. Increment `rd_ptr` (wraps mod `DEPTH`).
- **Simultaneous enqueue and dequeue:** `count` is unchanged and both pointers advance.
- **Stall:** `pause` = `core_we & full`.
  - A same-cycle dequeue does not clear `pause`.
  - The Core holds its ID-stage signals while paused, so the store is retried and enqueued the cycle after `full` drops.
- **Drain:** `mem_wvalid` = ~`empty`. `mem_waddr` = {entry[`rd_ptr`].addr, 2'b00}. `mem_wdata` = entry[`rd_ptr`].data. These are stable while `mem_wvalid & ~mem_wready`.
- **Forwarding:**
  - Compare `core_fetch_addr[AW-1:2]` against all valid entries.
  - On any hit, `core_rdata` = data of the youngest matching entry (nearest behind `wr_ptr`). Otherwise `core_rdata` = `mem_rdata`.
  - The head entry being dequeued this cycle is still valid and still forwards.
- **No same-cycle forwarding:** a store being enqueued this cycle is not forwarded. Core loads sampled in EXE are older than the ID-stage store.
- Address bits [1:0] are ignored for matching.

## Timing
- Reset values: `count`=0, `wr_ptr`=0, `rd_ptr`=0, `mem_wvalid`=0, `empty`=1, `pause`=0.
- Reset mid-operation: all buffered stores are discarded. Entry contents are don't-care.
- Store-to-visible-on-bus latency: 1 cycle when empty. The store is on `mem_w*` the cycle after `core_we`.
- Forwarding latency: 0 cycles after enqueue. A load the cycle after a store hits the buffer.
- Stall latency: `pause` is combinational in the same cycle as the blocked `core_we`. It is deasserted the cycle after the first dequeue from full.
- Throughput: one enqueue and one dequeue per cycle sustained.
- No combinational path from `mem_wready` to `mem_wvalid`, `mem_waddr` or `mem_wdata`.

## Structure
- Shared package `strontium_mem_pkg`: `WB_DEPTH` default, word-address width constant, and entry struct type {addr, data}.
- Sub-module `wbuf_fwd_match`: combinational youngest-hit priority select over `DEPTH` entries. Inputs: entries, valid mask, `wr_ptr`, query address. Outputs: hit and data.
- The top holds the pointers, count, storage array, and stall/drain logic.

## Test plan
- **Single store:** reset, `core_we` addr 0x100 data 0xDEADBEEF, `mem_wready`=1.
  - Next cycle: `mem_wvalid`=1, `mem_waddr`=0x100.
  - Cycle after: `empty`=1.
- **Forward youngest:** `mem_wready`=0; stores 0x200←0x11, then 0x200←0x22; then read `core_fetch_addr`=0x202 with `mem_rdata`=0x99.
  - `core_rdata`=0x22.
  - Read 0x204 → 0x99.
- **Full stall:** `mem_wready`=0; 4 stores to 0x0, 0x4, 0x8, 0xC; 5th `core_we` to 0x10.
  - `pause`=1 while `mem_wready` is held at 0.
  - Raise `mem_wready` for one cycle: `pause`=0 the next cycle, then 0x10 is enqueued.
  - Drain order is 0x0, 0x4, 0x8, 0xC, 0x10.
- **Wrap and simultaneous ops:** 12 back-to-back stores with `mem_wready` toggling 1/0.
  - `count` never exceeds 4.
  - Bus order matches issue order across pointer wrap.
- **Reset mid-drain:** 3 stores buffered, `reset` for 1 cycle.
  - Next cycle: `empty`=1, `mem_wvalid`=0, `pause`=0.
  - A read of a previously stored address returns `mem_rdata`.
